led_pattern_ctrl: RTL and testbench

Multi-channel LED pattern controller, the parametrised successor to the single-rate board blinker. A shared prescaler derives a slow tick from the system clock. Each of `N_CH` channels independently runs OFF, ON, BLINK or ONESHOT with its own half-period, reprogrammed at run time through a valid/ready config port. It sits between the board-level control logic (button handling, soft CPU) and the LED pins.

---
 rtl/led_pkg.sv | 32 +++
 rtl/led_tick_gen.sv | 33 +++
 rtl/led_pattern_ctrl.sv | 164 ++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - Shared mode, width and per-channel state types for led_pattern_ctrl
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } led_mode_e;

    localparam int DUTY_W = 8;
    // Widest half-period counter a channel can hold; PER_W must not exceed it.
    localparam int CNT_W  = 16;

    typedef struct packed {
        led_mode_e         mode;
        logic [CNT_W-1:0]  cnt;
        logic              phase;
        logic [DUTY_W-1:0] duty;
    } ch_state_t;

    function automatic logic eff_phase(input led_mode_e mode, input logic phase);
        logic ph;
        case (mode)
            MODE_OFF: ph = 1'b0;
            MODE_ON:  ph = 1'b1;
            default:  ph = phase;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - Prescaler producing a one-clk tick every CLK_F/TICK_HZ cycles
module led_tick_gen #(
    parameter int CLK_F   = 25000000,
    parameter int TICK_HZ = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int TICK_DIV = CLK_F / TICK_HZ;
    localparam int CW       = ($clog2(TICK_DIV) < 1) ? 1 : $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    if (TICK_DIV < 2) begin : g_div_chk
        $error("led_tick_gen: CLK_F/TICK_HZ must be at least 2");
    end

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - Multi-channel LED pattern controller; LED_PWM_EN adds per-channel PWM dimming
module led_pattern_ctrl #(
    parameter int  CLK_F   = 25000000,
    parameter int  TICK_HZ = 1000,
    parameter int  N_CH    = 4,
    parameter int  PER_W   = 10,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [PER_W-1:0] cfg_half,
    input  logic [7:0]       cfg_duty,
    output logic [N_CH-1:0]  led,
    output logic             tick
);

    import led_pkg::*;

    if (N_CH < 1 || N_CH > 16) begin : g_nch_chk
        $error("led_pattern_ctrl: N_CH must be 1..16");
    end
    if (PER_W < 1 || PER_W > CNT_W) begin : g_perw_chk
        $error("led_pattern_ctrl: PER_W out of range");
    end

    led_tick_gen #(
        .CLK_F   (CLK_F),
        .TICK_HZ (TICK_HZ)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    logic              pending;
    logic              accept;
    logic              commit;
    logic [CH_W-1:0]   sh_ch;
    led_mode_e         sh_mode;
    logic [PER_W-1:0]  sh_half;
    logic [PER_W-1:0]  sh_half_eff;
    logic [DUTY_W-1:0] commit_duty;
    logic [N_CH-1:0]   led_d;

    assign cfg_ready = ~pending;
    assign accept    = cfg_valid & ~pending;
    // Writes land only on tick edges so every channel keeps a common time base.
    assign commit    = pending & tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            sh_ch   <= '0;
            sh_mode <= MODE_OFF;
            sh_half <= '0;
        end else if (accept) begin
            pending <= 1'b1;
            sh_ch   <= cfg_ch;
            sh_mode <= led_mode_e'(cfg_mode);
            sh_half <= cfg_half;
        end else if (commit) begin
            pending <= 1'b0;
        end
    end

    assign sh_half_eff = (sh_half == '0) ? PER_W'(1) : sh_half;

`ifdef LED_PWM_EN
    logic [DUTY_W-1:0] sh_duty;
    logic [DUTY_W-1:0] pwm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_duty <= '0;
            pwm_q   <= '0;
        end else begin
            pwm_q <= pwm_q + DUTY_W'(1);
            if (accept) begin
                sh_duty <= cfg_duty;
            end
        end
    end

    assign commit_duty = sh_duty;
`else
    logic unused_cfg_duty;
    assign unused_cfg_duty = ^cfg_duty;
    assign commit_duty     = '0;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ch_state_t        st_q;
        ch_state_t        st_d;
        logic [PER_W-1:0] half_q;
        logic [PER_W-1:0] half_d;
        logic             at_end;

        assign at_end = (st_q.cnt == (CNT_W'(half_q) - CNT_W'(1)));

        always_comb begin
            st_d   = st_q;
            half_d = half_q;
            // A target index beyond N_CH matches no channel, so the write is dropped.
            if (commit && (sh_ch == CH_W'(i))) begin
                st_d.mode  = sh_mode;
                st_d.cnt   = '0;
                st_d.phase = (sh_mode == MODE_BLINK) || (sh_mode == MODE_ONESHOT);
                st_d.duty  = commit_duty;
                half_d     = sh_half_eff;
            end else if (tick) begin
                case (st_q.mode)
                    MODE_BLINK: begin
                        if (at_end) begin
                            st_d.cnt   = '0;
                            st_d.phase = ~st_q.phase;
                        end else begin
                            st_d.cnt = st_q.cnt + CNT_W'(1);
                        end
                    end
                    MODE_ONESHOT: begin
                        if (at_end) begin
                            st_d.mode  = MODE_OFF;
                            st_d.phase = 1'b0;
                        end else begin
                            st_d.cnt = st_q.cnt + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q   <= '0;
                half_q <= '0;
            end else begin
                st_q   <= st_d;
                half_q <= half_d;
            end
        end

`ifdef LED_PWM_EN
        assign led_d[i] = eff_phase(st_d.mode, st_d.phase) & (pwm_q < st_d.duty);
`else
        logic unused_duty;
        assign unused_duty = ^st_q.duty;
        assign led_d[i]    = eff_phase(st_d.mode, st_d.phase);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= '0;
        end else begin
            led <= led_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - Scoreboard bench for led_pattern_ctrl (TICK_DIV=10, N_CH=4 and a 3-channel instance)
module tb_led_pattern_ctrl;
    import led_pkg::*;

    localparam int TDIV = 10;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       cfg_valid  = 1'b0;
    logic       cfg_valid3 = 1'b0;
    logic [1:0] cfg_ch     = '0;
    logic [1:0] cfg_mode   = '0;
    logic [3:0] cfg_half   = '0;
    logic [7:0] cfg_duty   = '0;
    logic       cfg_ready;
    logic       cfg_ready3;
    logic       tick;
    logic       tick3;
    logic [3:0] led;
    logic [2:0] led3;

    always #5 clk = ~clk;

    led_pattern_ctrl #(.CLK_F(1000), .TICK_HZ(100), .N_CH(4), .PER_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_duty(cfg_duty),
        .led(led), .tick(tick)
    );

    led_pattern_ctrl #(.CLK_F(1000), .TICK_HZ(100), .N_CH(3), .PER_W(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_duty(cfg_duty),
        .led(led3), .tick(tick3)
    );

    typedef struct {
        int         at;
        int         sig;
        logic [3:0] mask;
        logic [3:0] exp;
        string      tag;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   cyc    = 0;
    int   r_cyc  = 0;
    int   max_at = 0;
    int   rdy_at[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic bit is_tick(input int t);
        return (t >= r_cyc) && (((t - r_cyc) % TDIV) == TDIV - 1);
    endfunction

    // Observed cycle at which a write accepted from cycle acc is visible.
    function automatic int next_commit(input int acc);
        int t;
        t = acc + 1;
        while (!is_tick(t)) t++;
        return t + 1;
    endfunction

    task automatic expect_at(input int at, input int sig, input logic [3:0] mask,
                             input logic [3:0] exp, input string tag);
        exp_t e;
        e.at = at; e.sig = sig; e.mask = mask; e.exp = exp; e.tag = tag;
        sbq.push_back(e);
        if (at > max_at) max_at = at;
    endtask

    always @(negedge clk) begin
        logic [3:0] obs;
        for (int k = sbq.size() - 1; k >= 0; k--) begin
            if (sbq[k].at == cyc) begin
                case (sbq[k].sig)
                    0:       obs = led;
                    1:       obs = {3'b0, cfg_ready};
                    2:       obs = {3'b0, tick};
                    3:       obs = {1'b0, led3};
                    4:       obs = {3'b0, cfg_ready3};
                    default: obs = {3'b0, tick3};
                endcase
                check_eq(sbq[k].tag, 32'(obs & sbq[k].mask), 32'(sbq[k].exp & sbq[k].mask));
                sbq.delete(k);
            end
        end
    end

    task automatic drain();
        while (cyc <= max_at) @(negedge clk);
    endtask

    // Called on a negedge; returns on the negedge right after the accepting edge.
    task automatic wr(input int d, input logic [1:0] ch, input logic [1:0] mode,
                      input logic [3:0] half, input logic [7:0] duty, input bit hold,
                      output int t_obs);
        int acc;
        int rs;
        acc = (cyc >= rdy_at[d]) ? cyc : rdy_at[d];
        rs  = (d == 0) ? 1 : 4;
        cfg_ch   = ch;
        cfg_mode = mode;
        cfg_half = half;
        cfg_duty = duty;
        if (d == 0) cfg_valid = 1'b1; else cfg_valid3 = 1'b1;
        t_obs = next_commit(acc);
        expect_at(acc + 1, rs, 4'h1, 4'h0, "ready_low_after_accept");
        expect_at(t_obs - 1, rs, 4'h1, 4'h0, "ready_low_at_commit");
        expect_at(t_obs, rs, 4'h1, 4'h1, "ready_high_after_commit");
        rdy_at[d] = t_obs;
        while (cyc < acc + 1) @(negedge clk);
        if (!hold) begin
            cfg_valid  = 1'b0;
            cfg_valid3 = 1'b0;
        end
    endtask

    task automatic expect_idle(input int from, input int to, input string tag);
        for (int t = from; t <= to; t++) begin
            expect_at(t, 0, 4'hf, 4'h0, tag);
            expect_at(t, 3, 4'h7, 4'h0, tag);
            expect_at(t, 1, 4'h1, 4'h1, "idle_ready");
            expect_at(t, 2, 4'h1, {3'b0, is_tick(t)}, "tick");
            expect_at(t, 5, 4'h1, {3'b0, is_tick(t)}, "tick3");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t1;
        int t2;
        int hi;

        repeat (3) @(negedge clk);
        check_eq("reset_led", 32'(led), 32'h0);
        check_eq("reset_ready", 32'(cfg_ready), 32'h1);
        check_eq("reset_tick", 32'(tick), 32'h0);
        rst_n = 1'b1;
        r_cyc = cyc;
        rdy_at[0] = r_cyc;
        rdy_at[1] = r_cyc;
        expect_idle(r_cyc + 1, r_cyc + 30, "idle_led");
        drain();

`ifndef LED_PWM_EN
        wr(0, 2'd0, MODE_BLINK, 4'd3, 8'hff, 1'b0, t0);
        for (int t = t0; t <= t0 + 60; t++) begin
            expect_at(t, 0, 4'h1, {3'b0, (((t - t0) / 30) % 2) == 0}, "blink3_led0");
            expect_at(t, 0, 4'he, 4'h0, "blink3_others");
        end
        drain();
        wr(0, 2'd0, MODE_OFF, 4'd3, 8'hff, 1'b0, t0);
        for (int t = t0; t <= t0 + 20; t++) expect_at(t, 0, 4'hf, 4'h0, "off_led");
        drain();

        for (int n = 0; n < 2; n++) begin
            if (n == 1) while (!is_tick(cyc)) @(negedge clk);
            wr(0, 2'd1, MODE_ONESHOT, 4'd2, 8'hff, 1'b0, t0);
            for (int t = t0; t <= t0 + 40; t++)
                expect_at(t, 0, 4'h2, {2'b0, t < t0 + 20, 1'b0}, "oneshot_led1");
            drain();
        end

        wr(0, 2'd2, MODE_BLINK, 4'd0, 8'hff, 1'b1, t1);
        for (int t = t1; t <= t1 + 40; t++)
            expect_at(t, 0, 4'h4, {1'b0, (((t - t1) / 10) % 2) == 0, 2'b0}, "half0_led2");
        wr(0, 2'd3, MODE_ON, 4'd5, 8'hff, 1'b0, t2);
        for (int t = cyc + 1; t < t2; t++) expect_at(t, 0, 4'h8, 4'h0, "b2b_led3_pre");
        for (int t = t2; t <= t2 + 10; t++) expect_at(t, 0, 4'h8, 4'h8, "b2b_led3_on");
        drain();

        wr(1, 2'd3, MODE_ON, 4'd1, 8'hff, 1'b0, t0);
        for (int t = t0; t <= t0 + 15; t++) expect_at(t, 3, 4'h7, 4'h0, "drop_ch3");
        drain();
        wr(1, 2'd2, MODE_ON, 4'd1, 8'hff, 1'b0, t0);
        for (int t = t0; t <= t0 + 5; t++) expect_at(t, 3, 4'h7, 4'h4, "n3_ch2_on");
        drain();

        while (((cyc - r_cyc) % TDIV) != 0) @(negedge clk);
        cfg_ch = 2'd0; cfg_mode = MODE_BLINK; cfg_half = 4'd1; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        check_eq("pre_arst_ready", 32'(cfg_ready), 32'h0);
        check_eq("pre_arst_led3", 32'(led[3]), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_led", 32'(led), 32'h0);
        check_eq("arst_ready", 32'(cfg_ready), 32'h1);
        check_eq("arst_led_n3", 32'(led3), 32'h0);
        check_eq("arst_ready_n3", 32'(cfg_ready3), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        r_cyc = cyc;
        rdy_at[0] = r_cyc;
        rdy_at[1] = r_cyc;
        expect_idle(r_cyc + 1, r_cyc + 40, "post_reset_led");
        drain();
`else
        wr(0, 2'd2, MODE_ON, 4'd1, 8'd64, 1'b0, t0);
        while (cyc < t0 + 1) @(negedge clk);
        hi = 0;
        repeat (256) begin
            @(negedge clk);
            hi += int'(led[2]);
        end
        check_eq("pwm_duty64", 32'(hi), 32'd64);
        drain();
        wr(0, 2'd2, MODE_ON, 4'd1, 8'd0, 1'b0, t0);
        while (cyc < t0 + 1) @(negedge clk);
        hi = 0;
        repeat (256) begin
            @(negedge clk);
            hi += int'(led[2]);
        end
        check_eq("pwm_duty0", 32'(hi), 32'd0);
        drain();
`endif

        check_eq("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
